// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the mux_scan channel selector.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // A single channel still needs a 1-bit index so the port list stays legal.
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_scan_sel.sv
// Combinational NUM_CH x WIDTH channel selector; err flags an index with no channel.
module mux_scan_sel
    import mux_scan_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int WIDTH  = 1,
    parameter int SEL_W  = sel_width(NUM_CH)
) (
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        data,
    output logic                    err
);

    // NOTE: defaults assigned first so every path drives both outputs (no latch).
    always_comb begin
        data = '0;
        err  = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (sel == SEL_W'(k)) begin
                data = in_data[k*WIDTH +: WIDTH];
                err  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_scan.sv
// Channel selector with direct and auto-scan modes feeding a one-entry valid/ready stage.
// Optional MUX_SCAN_PARITY_EN adds out_parity (XOR of the captured data).
module mux_scan
    import mux_scan_pkg::*;
#(
    parameter  int NUM_CH = 8,
    parameter  int WIDTH  = 1,
    localparam int SEL_W  = sel_width(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel_in,
    input  logic                    req,
    input  logic                    scan_start,
    input  logic                    scan_stop,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    sel_err,
    output logic                    busy
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic                    out_parity
`endif
);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   scan_ptr_q, scan_ptr_d, scan_ptr_inc;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic [SEL_W-1:0]   out_ch_q, out_ch_d;
    logic               sel_err_q, sel_err_d;
    logic               load_ok, cap_en;
    logic [SEL_W-1:0]   cap_sel;
    logic [WIDTH-1:0]   sel_data;
    logic               sel_bad;

    assign load_ok      = !out_valid_q || out_ready;
    assign scan_ptr_inc = (scan_ptr_q == SEL_W'(NUM_CH - 1)) ? '0 : scan_ptr_q + SEL_W'(1);

    mux_scan_sel #(
        .NUM_CH (NUM_CH),
        .WIDTH  (WIDTH),
        .SEL_W  (SEL_W)
    ) u_sel (
        .in_data (in_data),
        .sel     (cap_sel),
        .data    (sel_data),
        .err     (sel_bad)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            scan_ptr_q <= '0;
        end else begin
            state_q    <= state_d;
            scan_ptr_q <= scan_ptr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        scan_ptr_d = scan_ptr_q;
        case (state_q)
            IDLE: begin
                if (scan_start) begin
                    state_d    = SCAN;
                    scan_ptr_d = '0;
                end
            end
            SCAN: begin
                if (load_ok) scan_ptr_d = scan_ptr_inc;
                if (scan_stop) state_d = DRAIN;
            end
            DRAIN: begin
                // The held sample is the last one; leave once it is gone or going.
                if (load_ok) begin
                    state_d    = IDLE;
                    scan_ptr_d = '0;
                end
            end
            default: begin
                state_d    = IDLE;
                scan_ptr_d = '0;
            end
        endcase
    end

    always_comb begin
        cap_en  = 1'b0;
        cap_sel = sel_in;
        busy    = 1'b0;
        case (state_q)
            IDLE:  cap_en = req && load_ok && !scan_start;
            SCAN: begin
                cap_en  = load_ok;
                cap_sel = scan_ptr_q;
                busy    = 1'b1;
            end
            DRAIN: busy = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        sel_err_d   = sel_err_q;
        if (cap_en) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_ch_d    = cap_sel;
            sel_err_d   = sel_bad;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            sel_err_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign sel_err   = sel_err_q;

`ifdef MUX_SCAN_PARITY_EN
    logic out_parity_q, out_parity_d;

    // sel_data is already zero for a bad index, so parity falls to 0 there.
    always_comb begin
        out_parity_d = out_parity_q;
        if (cap_en) out_parity_d = ^sel_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_parity_q <= 1'b0;
        else        out_parity_q <= out_parity_d;
    end

    assign out_parity = out_parity_q;
`endif

endmodule

// File: tb/tb_mux_scan.sv
// Scoreboard bench for mux_scan: a 5x8 instance (stall, scan, range, parity, reset)
// and an 8x1 instance (the classic 8:1 bit select).
module tb_mux_scan;
    import mux_scan_pkg::*;

    typedef struct {
        logic [7:0] data;
        logic [2:0] ch;
        logic       err;
        logic       par;
    } exp_t;

    logic clk;
    logic rst_n;

    logic [39:0] d_in;
    logic [2:0]  d_sel, d_ch;
    logic        d_req, d_start, d_stop, d_valid, d_ready, d_err, d_busy;
    logic [7:0]  d_data;

    logic [7:0]  b_in;
    logic [2:0]  b_sel, b_ch;
    logic        b_req, b_start, b_stop, b_valid, b_ready, b_err, b_busy;
    logic [0:0]  b_data;

`ifdef MUX_SCAN_PARITY_EN
    logic d_par, b_par;
`endif

    exp_t d_q[$];
    exp_t b_q[$];
    exp_t d_e, b_e;
    int   n_assert = 0;
    int   n_fail   = 0;

    mux_scan #(.NUM_CH(5), .WIDTH(8)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (d_in),
        .sel_in     (d_sel),
        .req        (d_req),
        .scan_start (d_start),
        .scan_stop  (d_stop),
        .out_valid  (d_valid),
        .out_ready  (d_ready),
        .out_data   (d_data),
        .out_ch     (d_ch),
        .sel_err    (d_err),
        .busy       (d_busy)
`ifdef MUX_SCAN_PARITY_EN
        ,
        .out_parity (d_par)
`endif
    );

    mux_scan #(.NUM_CH(8), .WIDTH(1)) u_bit (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (b_in),
        .sel_in     (b_sel),
        .req        (b_req),
        .scan_start (b_start),
        .scan_stop  (b_stop),
        .out_valid  (b_valid),
        .out_ready  (b_ready),
        .out_data   (b_data),
        .out_ch     (b_ch),
        .sel_err    (b_err),
        .busy       (b_busy)
`ifdef MUX_SCAN_PARITY_EN
        ,
        .out_parity (b_par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required normal end");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] d_chan(input int k);
        return d_in[k*8 +: 8];
    endfunction

    task automatic push_d(input logic [2:0] s);
        exp_t e;
        e.err  = (s >= 3'd5);
        e.data = e.err ? 8'h00 : d_chan(int'(s));
        e.ch   = s;
        e.par  = ^e.data;
        d_q.push_back(e);
    endtask

    task automatic push_b(input logic [2:0] s);
        exp_t e;
        e.data = {7'b0, b_in[s]};
        e.ch   = s;
        e.err  = 1'b0;
        e.par  = b_in[s];
        b_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && d_valid && d_ready) begin
            n_assert++;
            if (d_q.size() == 0) begin
                n_fail++;
                $display("FAIL d_unexpected: got ch=%0d data=%h, required no sample", d_ch, d_data);
            end else begin
                d_e = d_q.pop_front();
                if (d_data !== d_e.data || d_ch !== d_e.ch || d_err !== d_e.err) begin
                    n_fail++;
                    $display("FAIL d_sample: got data=%h ch=%0d err=%b, required data=%h ch=%0d err=%b",
                             d_data, d_ch, d_err, d_e.data, d_e.ch, d_e.err);
                end
`ifdef MUX_SCAN_PARITY_EN
                n_assert++;
                if (d_par !== d_e.par) begin
                    n_fail++;
                    $display("FAIL d_parity: got %b, required %b", d_par, d_e.par);
                end
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_valid && b_ready) begin
            n_assert++;
            if (b_q.size() == 0) begin
                n_fail++;
                $display("FAIL b_unexpected: got ch=%0d data=%b, required no sample", b_ch, b_data);
            end else begin
                b_e = b_q.pop_front();
                if ({7'b0, b_data} !== b_e.data || b_ch !== b_e.ch || b_err !== b_e.err) begin
                    n_fail++;
                    $display("FAIL b_sample: got data=%b ch=%0d err=%b, required data=%b ch=%0d err=%b",
                             b_data, b_ch, b_err, b_e.data[0], b_e.ch, b_e.err);
                end
`ifdef MUX_SCAN_PARITY_EN
                n_assert++;
                if (b_par !== b_e.par) begin
                    n_fail++;
                    $display("FAIL b_parity: got %b, required %b", b_par, b_e.par);
                end
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_drained(input string name);
        repeat (3) tick();
        n_assert++;
        if (d_q.size() != 0 || b_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d/%0d samples outstanding, required 0/0",
                     name, d_q.size(), b_q.size());
            d_q.delete();
            b_q.delete();
        end
    endtask

    task automatic test_reset();
        #2;
        n_assert++;
        if ({d_valid, d_data, d_ch, d_err, d_busy} !== '0 ||
            {b_valid, b_data, b_ch, b_err, b_busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got d=%b_%h_%0d_%b_%b b=%b_%b_%0d_%b_%b, required all 0",
                     d_valid, d_data, d_ch, d_err, d_busy, b_valid, b_data, b_ch, b_err, b_busy);
        end
        n_assert++;
        if (u_dut.state_q !== IDLE || u_dut.scan_ptr_q !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: got state=%0d ptr=%0d, required IDLE/0",
                     u_dut.state_q, u_dut.scan_ptr_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_direct();
        logic [2:0] sels[4] = '{3'd1, 3'd2, 3'd3, 3'd7};
        b_in    = 8'b1010_0110;
        b_ready = 1'b1;
        foreach (sels[i]) begin
            b_req = 1'b1;
            b_sel = sels[i];
            push_b(sels[i]);
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            b_sel = 3'($urandom_range(0, 7));
            push_b(b_sel);
            tick();
        end
        b_req = 1'b0;
        check_drained("direct");
    endtask

    task automatic test_stall();
        d_ready = 1'b0;
        d_in[39:32] = 8'h3C;
        d_req = 1'b1;
        d_sel = 3'd4;
        push_d(3'd4);
        tick();
        d_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d_in[39:32] = 8'hA0 + 8'(i);
            d_req = (i == 1);
            d_sel = 3'd1;
            @(negedge clk);
            n_assert++;
            if (d_valid !== 1'b1 || d_data !== 8'h3C || d_ch !== 3'd4) begin
                n_fail++;
                $display("FAIL stall_hold: got valid=%b data=%h ch=%0d, required 1/3c/4",
                         d_valid, d_data, d_ch);
            end
            tick();
        end
        d_req   = 1'b0;
        d_ready = 1'b1;
        tick();
        d_ready = 1'b0;
        @(negedge clk);
        n_assert++;
        if (d_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release: got valid=%b, required 0", d_valid);
        end
        d_ready = 1'b1;
        check_drained("stall");
    endtask

    task automatic test_scan();
        logic [2:0] seq[7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
        d_ready = 1'b1;
        d_start = 1'b1;
        d_req   = 1'b1;
        d_sel   = 3'd2;
        foreach (seq[i]) push_d(seq[i]);
        tick();
        d_start = 1'b0;
        d_sel   = 3'd3;
        @(negedge clk);
        n_assert++;
        if (d_busy !== 1'b1 || u_dut.state_q !== SCAN) begin
            n_fail++;
            $display("FAIL scan_enter: got busy=%b state=%0d, required 1/SCAN", d_busy, u_dut.state_q);
        end
        repeat (6) tick();
        d_stop = 1'b1;
        tick();
        d_stop = 1'b0;
        d_req  = 1'b0;
        @(negedge clk);
        n_assert++;
        if (d_busy !== 1'b1 || u_dut.state_q !== DRAIN) begin
            n_fail++;
            $display("FAIL scan_drain: got busy=%b state=%0d, required 1/DRAIN", d_busy, u_dut.state_q);
        end
        tick();
        @(negedge clk);
        n_assert++;
        if (d_busy !== 1'b0 || u_dut.state_q !== IDLE || u_dut.scan_ptr_q !== 3'd0) begin
            n_fail++;
            $display("FAIL scan_idle: got busy=%b state=%0d ptr=%0d, required 0/IDLE/0",
                     d_busy, u_dut.state_q, u_dut.scan_ptr_q);
        end
        check_drained("scan");
    endtask

    task automatic test_range();
        logic [2:0] sels[5] = '{3'd6, 3'd2, 3'd5, 3'd7, 3'd4};
        d_ready = 1'b1;
        foreach (sels[i]) begin
            d_req = 1'b1;
            d_sel = sels[i];
            push_d(sels[i]);
            tick();
        end
        d_req = 1'b0;
        check_drained("range");
    endtask

    task automatic test_parity();
        d_ready    = 1'b1;
        d_in[7:0]  = 8'h07;
        d_in[15:8] = 8'h0F;
        d_req = 1'b1;
        d_sel = 3'd0;
        push_d(3'd0);
        tick();
        d_sel = 3'd1;
        push_d(3'd1);
`ifdef MUX_SCAN_PARITY_EN
        @(negedge clk);
        n_assert++;
        if (d_par !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_07: got %b, required 1", d_par);
        end
`endif
        tick();
        d_req = 1'b0;
`ifdef MUX_SCAN_PARITY_EN
        @(negedge clk);
        n_assert++;
        if (d_par !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_0f: got %b, required 0", d_par);
        end
`endif
        check_drained("parity");
    endtask

    task automatic test_async_reset();
        d_ready = 1'b0;
        d_start = 1'b1;
        tick();
        d_start = 1'b0;
        tick();
        tick();
        n_assert++;
        if (d_valid !== 1'b1 || d_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_setup: got valid=%b busy=%b, required 1/1", d_valid, d_busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_assert++;
        if ({d_valid, d_data, d_ch, d_err, d_busy} !== '0) begin
            n_fail++;
            $display("FAIL areset_outputs: got %b_%h_%0d_%b_%b, required all 0",
                     d_valid, d_data, d_ch, d_err, d_busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        n_assert++;
        if (u_dut.state_q !== IDLE || u_dut.scan_ptr_q !== 3'd0 || d_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_after: got state=%0d ptr=%0d valid=%b, required IDLE/0/0",
                     u_dut.state_q, u_dut.scan_ptr_q, d_valid);
        end
        d_ready = 1'b1;
        check_drained("areset");
    endtask

    initial begin
        rst_n   = 1'b0;
        d_in    = {8'h3C, 8'h5A, 8'h96, 8'hE1, 8'h0F};
        d_sel   = '0;
        d_req   = 1'b0;
        d_start = 1'b0;
        d_stop  = 1'b0;
        d_ready = 1'b0;
        b_in    = '0;
        b_sel   = '0;
        b_req   = 1'b0;
        b_start = 1'b0;
        b_stop  = 1'b0;
        b_ready = 1'b0;

        test_reset();
        test_direct();
        test_stall();
        test_scan();
        test_range();
        test_parity();
        test_async_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
